dbg_mem_port: RTL and testbench

- Debug-side initiator for port B of the data memory (A2/WD2/WE2/RD2) inside the Write Back segment register.
- Converts a host command stream (single or burst word read/write) into port-B accesses.
- Accounts for the one-cycle synchronous read latency of the block RAM.
- Gives the debug host a valid/ready handshake on command, write-data and read-data channels, independent of the CPU pipeline on port A.

---
 rtl/dbg_mem_port.sv | 144 ++++++++++++++
 tb/tb_dbg_mem_port.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_mem_port.sv
// dbg_mem_port: debug-host initiator for data-memory port B (A2/WD2/WE2/RD2).
// Turns single/burst read and write commands into port-B accesses and absorbs
// the one-cycle synchronous read latency of the block RAM.
// Optional build macro: DBG_MEM_RANGE_CHECK_EN enables the sticky range fault
// on err; when it is undefined no check is made and err stays 0.
module dbg_mem_port #(
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       cmd_be,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             rd_last,
  output logic [31:0]      A2,
  output logic [31:0]      WD2,
  output logic [3:0]       WE2,
  input  logic [31:0]      RD2,
  output logic             busy,
  output logic             err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_STEP = 32'd4;

`ifdef DBG_MEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [31:0]      addr;
  logic [LEN_W-1:0] cnt;
  logic [3:0]       be;
  logic             fault;
  logic             cnt_zero;
  logic             range_fault;

  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WR);
  assign busy      = (state != S_IDLE) || (WE2 != 4'h0);
  assign cnt_zero  = (cnt == '0);

  // Last word of the burst at or beyond the end of memory (33-bit sum, no wrap)
  assign range_fault = RANGE_CHECK &&
    ((33'({1'b0, cmd_addr[31:2]}) + 33'(cmd_len)) >= 33'(DEPTH_WORDS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (cmd_valid) state_next = cmd_write ? S_WR : S_RD_ADDR;
      S_WR:      if (wr_valid && cnt_zero) state_next = S_IDLE;
      S_RD_ADDR: state_next = S_RD_DATA;
      S_RD_DATA: state_next = S_RD_RESP;
      S_RD_RESP: if (rd_ready) state_next = cnt_zero ? S_IDLE : S_RD_ADDR;
      default:   state_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping and registered port-B / read-channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      cnt      <= '0;
      be       <= '0;
      fault    <= 1'b0;
      err      <= 1'b0;
      A2       <= '0;
      WD2      <= '0;
      WE2      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      // Write enables are one-cycle pulses; any cycle without a beat clears them
      WE2 <= 4'h0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr  <= cmd_addr & WORD_MASK;
            cnt   <= cmd_len;
            be    <= cmd_be;
            fault <= range_fault;
            if (range_fault) err <= 1'b1;
            if (!cmd_write) A2 <= cmd_addr & WORD_MASK;
          end
        end
        S_WR: begin
          if (wr_valid) begin
            A2   <= addr;
            WD2  <= wr_data;
            WE2  <= fault ? 4'h0 : be;
            addr <= addr + WORD_STEP;
            if (!cnt_zero) cnt <= cnt - LEN_W'(1);
          end
        end
        S_RD_DATA: begin
          rd_data  <= fault ? 32'h0 : RD2;
          rd_last  <= cnt_zero;
          rd_valid <= 1'b1;
        end
        S_RD_RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (!cnt_zero) begin
              cnt <= cnt - LEN_W'(1);
              A2  <= A2 + WORD_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_mem_port.sv
// Testbench for dbg_mem_port: directed test-plan steps followed by random
// command traffic, checked against a byte-lane memory model kept here.
module tb_dbg_mem_port;

  localparam int unsigned LEN_W       = 4;
  localparam int unsigned DEPTH_WORDS = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [3:0]       cmd_be;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic             rd_last;
  logic [31:0]      A2;
  logic [31:0]      WD2;
  logic [3:0]       WE2;
  logic [31:0]      RD2;
  logic             busy;
  logic             err;

  int n_asserts = 0;
  int n_fail    = 0;
  bit exp_err   = 1'b0;

  logic [31:0] wq [$];
  logic [31:0] rq [$];

  // Block RAM behind port B (read-first, one-cycle read latency)
  bit [31:0] ram [8192];
  // Reference memory contents as the host expects them
  bit [31:0] ref_mem [8192];

  dbg_mem_port #(.LEN_W(LEN_W), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .A2(A2), .WD2(WD2), .WE2(WE2), .RD2(RD2),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    RD2 <= ram[A2[14:2]];
    for (int b = 0; b < 4; b++)
      if (WE2[b]) ram[A2[14:2]][8*b +: 8] <= WD2[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit range_fault(input logic [31:0] addr, input int len);
`ifdef DBG_MEM_RANGE_CHECK_EN
    return (longint'(addr >> 2) + longint'(len)) >= longint'(DEPTH_WORDS);
`else
    return (addr == 32'h0) && (len < 0);
`endif
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[14:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Inputs the design must ignore in the current state
  task automatic noise();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = LEN_W'($urandom);
    cmd_be    = 4'($urandom);
  endtask

  task automatic quiet();
    cmd_valid = 1'b0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
  endtask

  // Write burst of wq; gap<0 picks 0..2 idle cycles before each beat at random
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int gap);
    int          len;
    int          g;
    logic [31:0] a;
    logic [31:0] ea;
    bit          flt;
    len = wq.size() - 1;
    a   = addr & 32'hFFFF_FFFC;
    flt = range_fault(addr, len);
    chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr;
    cmd_len = LEN_W'(len); cmd_be = be;
    tick();
    if (flt) exp_err = 1'b1;
    chk("wr_err_accept", 32'(err), 32'(exp_err));
    for (int i = 0; i <= len; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        noise();
        wr_valid = 1'b0; wr_data = $urandom; rd_ready = 1'($urandom);
        tick();
        chk("wr_gap_we2", 32'(WE2), 32'd0);
        chk("wr_gap_ready", 32'(wr_ready), 32'd1);
      end
      noise();
      wr_valid = 1'b1; wr_data = wq[i];
      tick();
      ea = a + 32'(4 * i);
      chk("wr_a2", A2, ea);
      chk("wr_wd2", WD2, wq[i]);
      chk("wr_we2", 32'(WE2), flt ? 32'd0 : 32'(be));
      if (!flt) ref_write(ea, wq[i], be);
    end
    quiet();
    tick();
    chk("wr_end_we2", 32'(WE2), 32'd0);
    chk("wr_end_busy", 32'(busy), 32'd0);
    chk("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  // Read burst; stall<0 holds rd_ready low 0..2 cycles per beat at random.
  // abort_at>=0 asserts rst while that beat is being presented.
  task automatic do_read(input logic [31:0] addr, input int len, input int stall,
                         input int abort_at);
    int          s;
    logic [31:0] a;
    logic [31:0] ea;
    logic [31:0] ed;
    bit          flt;
    a   = addr & 32'hFFFF_FFFC;
    flt = range_fault(addr, len);
    rq.delete();
    chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr;
    cmd_len = LEN_W'(len); cmd_be = 4'($urandom);
    tick();
    if (flt) exp_err = 1'b1;
    chk("rd_err_accept", 32'(err), 32'(exp_err));
    for (int i = 0; i <= len; i++) begin
      ea = a + 32'(4 * i);
      ed = flt ? 32'h0 : ref_mem[ea[14:2]];
      chk("rd_a2", A2, ea);
      noise(); wr_valid = 1'($urandom); wr_data = $urandom; rd_ready = 1'($urandom);
      tick();
      chk("rd_valid_early", 32'(rd_valid), 32'd0);
      noise(); wr_valid = 1'($urandom); rd_ready = 1'($urandom);
      tick();
      chk("rd_valid_latency", 32'(rd_valid), 32'd1);
      chk("rd_data", rd_data, ed);
      chk("rd_last", 32'(rd_last), (i == len) ? 32'd1 : 32'd0);
      rq.push_back(rd_data);
      s = (stall < 0) ? int'($urandom_range(2, 0)) : stall;
      for (int k = 0; k < s; k++) begin
        noise(); rd_ready = 1'b0;
        tick();
        chk("rd_hold_valid", 32'(rd_valid), 32'd1);
        chk("rd_hold_data", rd_data, ed);
        chk("rd_hold_last", 32'(rd_last), (i == len) ? 32'd1 : 32'd0);
        chk("rd_hold_a2", A2, ea);
        chk("rd_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      if (i == abort_at) begin
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_we2", 32'(WE2), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        return;
      end
      noise(); rd_ready = 1'b1;
      tick();
      chk("rd_taken", 32'(rd_valid), 32'd0);
    end
    quiet();
    chk("rd_end_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rd_end_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] ra;
    logic [3:0]  rbe;
    int          rlen;

    rst = 1'b1; quiet();
    cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_be = '0; wr_data = '0;
    tick(); tick();
    chk("reset_a2", A2, 32'h0);
    chk("reset_wd2", WD2, 32'h0);
    chk("reset_we2", 32'(WE2), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_rd_last", 32'(rd_last), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single word write then read back
    wq = '{32'hA5A51234};
    do_write(32'h10, 4'hF, 0);
    do_read(32'h10, 0, 0, -1);
    chk("single_readback", rq[0], 32'hA5A51234);

    // Burst write with wr_valid low on alternate cycles, stalled burst read
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(32'h100, 4'hF, 1);
    do_read(32'h100, 3, 5, -1);
    for (int i = 0; i < 4; i++) chk("burst_readback", rq[i], 32'(i + 1));

    // Byte-lane write on an unaligned command address
    wq = '{32'h11223344};
    do_write(32'h20, 4'hF, 0);
    wq = '{32'hFFFFFFFF};
    do_write(32'h23, 4'b0010, 0);
    do_read(32'h20, 0, 1, -1);
    chk("byte_lane_readback", rq[0], 32'h1122FF44);

    // Zero byte enables leave memory unchanged
    wq = '{32'hDEADBEEF, 32'h0BADF00D};
    do_write(32'h10, 4'h0, 0);
    do_read(32'h10, 0, 0, -1);
    chk("be0_readback", rq[0], 32'hA5A51234);

    // Reset while the second of four beats is presented, then a normal command
    do_read(32'h100, 3, 2, 1);
    do_read(32'h104, 1, 0, -1);
    chk("post_rst_read0", rq[0], 32'd2);
    chk("post_rst_read1", rq[1], 32'd3);

    // End-of-memory boundary
    wq = '{32'hCAFEF00D};
    do_write(32'h3FFC, 4'hF, 0);
    do_read(32'h3FFC, 1, 0, -1);
`ifdef DBG_MEM_RANGE_CHECK_EN
    chk("range_err", 32'(err), 32'd1);
    chk("range_beat0", rq[0], 32'h0);
`else
    chk("range_err", 32'(err), 32'd0);
    chk("range_beat0", rq[0], 32'hCAFEF00D);
`endif
    chk("range_beat1", rq[1], 32'h0);
    wq = '{32'h1, 32'h2};
    do_write(32'h3FFC, 4'hF, 0);
    do_read(32'h3FFC, 0, 0, -1);

    // Random traffic in a small window
    for (int n = 0; n < 24; n++) begin
      ra   = 32'($urandom_range(1023, 0));
      rlen = int'($urandom_range(15, 0));
      if (1'($urandom)) begin
        rbe = 4'($urandom);
        wq.delete();
        for (int i = 0; i <= rlen; i++) wq.push_back($urandom);
        do_write(ra, rbe, -1);
      end else begin
        do_read(ra, rlen, -1, -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
